sb_iter: RTL and testbench

- Parametrised, handshaked successor of the Simeck-style SB box used in the SpoC/sLiSCP-light permutation datapath.
- Runs NUM_RND Feistel rounds on a WIDTH-bit word, UNROLL rounds per clock, with one round-constant bit consumed per round.
- Valid/ready on both sides, so the permutation controller can stall and flush it.
- Sits between the state-column mux and the permutation state register.

---
 rtl/sb_iter.sv | 88 ++++++++
 tb/tb_sb_iter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_iter.sv
// sb_iter: handshaked Simeck-style Feistel SB box; NUM_RND rounds, UNROLL per clock,
// one round-constant bit per round, valid/ready on both sides with sync flush.
module sb_iter #(
  parameter int WIDTH   = 48,
  parameter int NUM_RND = 6,
  parameter int UNROLL  = 1,
  parameter int ROT_A   = 5,
  parameter int ROT_B   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [NUM_RND-1:0] in_rc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(NUM_RND + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_RND - UNROLL);
  localparam logic [CW-1:0] STEP = CW'(UNROLL);

  if (WIDTH % 2 != 0 || NUM_RND < 1 || UNROLL < 1 || NUM_RND % UNROLL != 0 ||
      ROT_A < 1 || ROT_A > H - 1 || ROT_B < 1 || ROT_B > H - 1) begin : g_bad
    $error("sb_iter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     st_reg;
  logic [NUM_RND-1:0]   rc_reg;
  logic [CW-1:0]        rnd_ctr;
  logic [WIDTH-1:0]     chain [UNROLL+1];

  function automatic logic [H-1:0] rotl(input logic [H-1:0] u, input int n);
    return (u << n) | (u >> (H - n));
  endfunction

  function automatic logic [WIDTH-1:0] round_fn(input logic [WIDTH-1:0] s, input logic rc);
    logic [H-1:0] u;
    u = s[WIDTH-1:H];
    return {((rotl(u, ROT_A) & u) ^ rotl(u, ROT_B)) ^ s[H-1:0] ^ {{(H-1){1'b1}}, rc}, u};
  endfunction

  // rc_reg[r] always holds the constant for the r-th round of this cycle's chain
  assign chain[0] = st_reg;
  for (genvar r = 0; r < UNROLL; r++) begin : g_rnd
    assign chain[r+1] = round_fn(chain[r], rc_reg[r]);
  end

  always_comb begin
    state_nx = clr                                ? IDLE :
               (state == IDLE && in_valid)        ? BUSY :
               (state == BUSY && rnd_ctr == LAST) ? DONE :
               (state == DONE && out_ready)       ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      st_reg  <= '0;
      rc_reg  <= '0;
      rnd_ctr <= '0;
    end else if (state == IDLE && in_valid) begin
      st_reg  <= in_data;
      rc_reg  <= in_rc;
      rnd_ctr <= '0;
    end else if (state == BUSY) begin
      st_reg  <= chain[UNROLL];
      rc_reg  <= rc_reg >> UNROLL;
      rnd_ctr <= rnd_ctr + STEP;
    end
  end

  assign in_ready  = state == IDLE;
  assign busy      = state == BUSY;
  assign out_valid = state == DONE;
  assign out_data  = st_reg;
endmodule

// File: tb/tb_sb_iter.sv
// tb_sb_iter: scoreboard bench running five sb_iter configurations in lockstep
// (NUM_RND=6 at UNROLL 1/2/3, plus NUM_RND=1 and NUM_RND=2) against a round-level model.
module tb_sb_iter;
  localparam int NR [5] = '{6, 6, 6, 1, 2};
  localparam int UR [5] = '{1, 2, 3, 1, 1};

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [47:0] in_data;
  logic [5:0]  in_rc;
  logic [4:0]  ir, ov, bz;
  logic [47:0] od [5];

  logic [47:0] q  [5][$];
  int          aq [5][$];
  bit          seen [5];
  logic [47:0] last_out [5];
  logic [47:0] held [5];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] rl(input logic [23:0] x, input int n);
    logic [47:0] w;
    w = {x, x};
    return w[47-n -: 24];
  endfunction

  // Straight Feistel iteration on the two halves, one round at a time
  function automatic logic [47:0] model(input logic [47:0] d, input logic [5:0] rc, input int n);
    logic [23:0] u, l, t;
    u = d[47:24];
    l = d[23:0];
    for (int r = 0; r < n; r++) begin
      t = (rl(u, 5) & u) ^ rl(u, 1) ^ l ^ {23'h7FFFFF, rc[r]};
      l = u;
      u = t;
    end
    return {u, l};
  endfunction

  for (genvar k = 0; k < 5; k++) begin : g
    logic [47:0] e;
    sb_iter #(.WIDTH(48), .NUM_RND(NR[k]), .UNROLL(UR[k]), .ROT_A(5), .ROT_B(1)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[k]),
      .in_data(in_data), .in_rc(in_rc[NR[k]-1:0]), .out_valid(ov[k]),
      .out_ready(out_ready), .out_data(od[k]), .busy(bz[k]));

    always @(negedge clk) if (rst) begin
      if (ov[k] && !seen[k]) begin
        seen[k] = 1'b1;
        if (aq[k].size() == 0) chk(1'b0, $sformatf("unexpected_valid[%0d]", k), 48'(ov[k]), 48'd0);
        else chk(cyc - aq[k][0] == NR[k] / UR[k], $sformatf("latency[%0d]", k),
                 48'(cyc - aq[k][0]), 48'(NR[k] / UR[k]));
      end
      if (ov[k] && out_ready && !clr) begin
        if (q[k].size() == 0) chk(1'b0, $sformatf("unexpected_out[%0d]", k), od[k], 48'd0);
        else begin
          e = q[k].pop_front();
          void'(aq[k].pop_front());
          chk(od[k] === e, $sformatf("data[%0d]", k), od[k], e);
        end
        last_out[k] = od[k];
        seen[k] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] d, input logic [5:0] rc);
    in_data  = d;
    in_rc    = rc;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q[i].push_back(model(d, rc, NR[i]));
      aq[i].push_back(cyc + 1);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 5; i++) begin
      q[i].delete();
      aq[i].delete();
      seen[i] = 1'b0;
    end
  endtask

  task automatic drain_check(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) n += q[i].size();
    chk(n == 0, nm, 48'(n), 48'd0);
  endtask

  task automatic idle_check(input string nm);
    for (int i = 0; i < 5; i++)
      chk(ir[i] === 1'b1 && ov[i] === 1'b0 && bz[i] === 1'b0 && od[i] === 48'd0,
          $sformatf("%s[%0d]", nm, i), {od[i][44:0], ir[i], ov[i], bz[i]}, 48'd4);
  endtask

  task automatic wait_all_valid(input string nm);
    int n;
    n = 0;
    while (ov != 5'h1F && n < 12) begin
      tick();
      n++;
    end
    chk(ov == 5'h1F, nm, 48'(ov), 48'h1F);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_rc = '0;
    #3;
    idle_check("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    send(48'd0, 6'b000001);
    repeat (8) tick();
    drain_check("drain_dir1");
    chk(last_out[3] === 48'hFFFFFF000000, "nr1_value", last_out[3], 48'hFFFFFF000000);
    send(48'd0, 6'b000000);
    repeat (8) tick();
    drain_check("drain_dir2");
    chk(last_out[4] === 48'hFFFFDDFFFFFE, "nr2_value", last_out[4], 48'hFFFFDDFFFFFE);

    // backpressure in DONE with input pulses that must be ignored
    out_ready = 1'b0;
    send({16'($urandom), $urandom}, 6'($urandom));
    wait_all_valid("bp_valid");
    for (int i = 0; i < 5; i++) held[i] = od[i];
    repeat (10) begin
      in_valid = 1'b1;
      in_data  = {16'($urandom), $urandom};
      in_rc    = 6'($urandom);
      tick();
      for (int i = 0; i < 5; i++)
        chk(od[i] === held[i] && ir[i] === 1'b0 && ov[i] === 1'b1,
            $sformatf("bp_hold[%0d]", i), od[i], held[i]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++)
      chk(ir[i] === 1'b1 && ov[i] === 1'b0, $sformatf("bp_release[%0d]", i), {ir[i], ov[i]}, 48'h2);
    drain_check("drain_bp");

    // asynchronous reset while the UNROLL=1 instance is at rnd_ctr=3
    send({16'($urandom), $urandom}, 6'($urandom));
    repeat (3) tick();
    chk(bz[0] === 1'b1 && ir[0] === 1'b0, "busy_state", {bz[0], ir[0]}, 48'h2);
    #1 rst = 1'b0;
    #1 idle_check("async_rst");
    flush();
    #1 rst = 1'b1;
    tick();
    send({16'($urandom), $urandom}, 6'($urandom));
    repeat (8) tick();
    drain_check("drain_post_rst");

    // flush while BUSY
    send({16'($urandom), $urandom}, 6'($urandom));
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle_check("clr_busy");
    flush();

    // flush in DONE together with out_ready
    out_ready = 1'b0;
    send({16'($urandom), $urandom}, 6'($urandom));
    wait_all_valid("clr_done_valid");
    out_ready = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle_check("clr_done");
    flush();
    tick();

    for (int n = 0; n < 200; n++) begin
      send({16'($urandom), $urandom}, 6'($urandom));
      repeat (8) tick();
    end
    drain_check("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
